// File: rtl/microprocessor_pkg.sv
// -----------------------------------------------------------------------------
// microprocessor_pkg
// Shared definitions for the microprocessor: opcode constants, control-word
// bit positions, PC-source (PCMUX) encodings and the fetch-stage state type.
// No ports; imported by fetch_unit and pc_next.
// -----------------------------------------------------------------------------
package microprocessor_pkg;

    // Opcode occupies the top nibble of the instruction register.
    localparam logic [3:0] OP_NOP = 4'b1110;

    // Control-word bit positions used by the fetch stage.
    localparam int CTRL_PCLOAD   = 0;
    localparam int CTRL_MUX1     = 1;
    localparam int CTRL_MUX2     = 2;
    localparam int CTRL_BRANCHE  = 3;
    localparam int CTRL_BRANCHNE = 4;

    // PC source select, {MUX2, MUX1}.
    typedef enum logic [1:0] {
        PC_INC = 2'b00,
        PC_BR  = 2'b01,
        PC_JMP = 2'b10,
        PC_JR  = 2'b11
    } pcmux_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_EXEC  = 2'b01,
        ST_HALT  = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// -----------------------------------------------------------------------------
// pc_next
// Combinational next-PC selection and branch-taken evaluation.
// Ports:
//   i_pc        current program counter
//   i_ir_lo     IR[11:0]; [11:0] is the jump target, [5:0] the branch offset
//   i_pcmux     PC source select
//   i_branche   branch if ALU zero
//   i_branchne  branch if ALU non-zero
//   i_alu_zero  ALU zero flag
//   i_jr_addr   register target for JR
//   o_pc_inc    PC+1 (also the JAL link address)
//   o_next_pc   selected next PC
// All arithmetic wraps modulo 2^PC_W.
// -----------------------------------------------------------------------------
module pc_next
    import microprocessor_pkg::*;
#(
    parameter int PC_W = 16
) (
    input  logic [PC_W-1:0] i_pc,
    input  logic [11:0]     i_ir_lo,
    input  pcmux_e          i_pcmux,
    input  logic            i_branche,
    input  logic            i_branchne,
    input  logic            i_alu_zero,
    input  logic [PC_W-1:0] i_jr_addr,
    output logic [PC_W-1:0] o_pc_inc,
    output logic [PC_W-1:0] o_next_pc
);

    logic            w_taken;
    logic [PC_W-1:0] w_offset;
    logic [PC_W-1:0] w_target;

    assign o_pc_inc = i_pc + PC_W'(1);
    assign w_taken  = (i_branche & i_alu_zero) | (i_branchne & ~i_alu_zero);
    // Sign-extended 6-bit offset; negative offsets wrap through zero.
    assign w_offset = {{(PC_W-6){i_ir_lo[5]}}, i_ir_lo[5:0]};
    assign w_target = {{(PC_W-12){1'b0}}, i_ir_lo};

    always_comb begin
        o_next_pc = o_pc_inc;
        case (i_pcmux)
            PC_INC: o_next_pc = o_pc_inc;
            PC_BR:  o_next_pc = w_taken ? (o_pc_inc + w_offset) : o_pc_inc;
            PC_JMP: o_next_pc = w_target;
            PC_JR:  o_next_pc = i_jr_addr;
            default: o_next_pc = o_pc_inc;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch / program-counter stage. Owns PC and IR, fetches over a
// req/ack handshake, presents the opcode, computes the next PC from the
// control word and stops on HLT (PCLOAD=0 in EXEC).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_req/imem_addr       fetch request and address (= PC)
//   imem_ack/imem_rdata      memory handshake and returned instruction
//   opcode, instr            IR top nibble and full IR
//   ctrl, alu_zero, jr_addr  control word, ALU zero flag, JR target
//   exec_en                  one-cycle execute pulse
//   link_addr                PC+1 for JAL write-back
//   halted                   high while halted
//   resume                   (FETCH_RESUME_EN only) leave HALT at PC+1
// Build option: define FETCH_RESUME_EN to add the resume input.
// -----------------------------------------------------------------------------
module fetch_unit
    import microprocessor_pkg::*;
#(
    parameter int          PC_W     = 16,
    parameter int          INSTR_W  = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [3:0]         opcode,
    output logic [INSTR_W-1:0] instr,
    input  logic [15:0]        ctrl,
    input  logic               alu_zero,
    input  logic [PC_W-1:0]    jr_addr,
    output logic               exec_en,
    output logic [PC_W-1:0]    link_addr,
    output logic               halted
`ifdef FETCH_RESUME_EN
    ,
    input  logic               resume
`endif
);

    localparam logic [INSTR_W-1:0] IR_RESET = {OP_NOP, {(INSTR_W-4){1'b0}}};

    fetch_state_e       r_state;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic [PC_W-1:0]    w_next_pc;
    logic [PC_W-1:0]    w_pc_inc;
    logic               w_unused_ctrl;

    // Control bits above BRANCHNE belong to the datapath, not this stage.
    assign w_unused_ctrl = &{1'b0, ctrl[15:5]};

    pc_next #(
        .PC_W (PC_W)
    ) u_pc_next (
        .i_pc       (r_pc),
        .i_ir_lo    (r_ir[11:0]),
        .i_pcmux    (pcmux_e'(ctrl[CTRL_MUX2:CTRL_MUX1])),
        .i_branche  (ctrl[CTRL_BRANCHE]),
        .i_branchne (ctrl[CTRL_BRANCHNE]),
        .i_alu_zero (alu_zero),
        .i_jr_addr  (jr_addr),
        .o_pc_inc   (w_pc_inc),
        .o_next_pc  (w_next_pc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_FETCH;
            r_pc    <= PC_W'(RESET_PC);
            r_ir    <= IR_RESET;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (imem_ack) begin
                        r_ir    <= imem_rdata;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (ctrl[CTRL_PCLOAD]) begin
                        r_pc    <= w_next_pc;
                        r_state <= ST_FETCH;
                    end else begin
                        r_state <= ST_HALT;
                    end
                end
                ST_HALT: begin
`ifdef FETCH_RESUME_EN
                    // Continue with the instruction after the HLT.
                    if (resume) begin
                        r_pc    <= w_pc_inc;
                        r_state <= ST_FETCH;
                    end
`endif
                end
                default: r_state <= ST_FETCH;
            endcase
        end
    end

    // Request is gated by rst so it drops in the same cycle reset is raised.
    assign imem_req  = (r_state == ST_FETCH) && !rst;
    assign imem_addr = r_pc;
    assign opcode    = r_ir[INSTR_W-1 -: 4];
    assign instr     = r_ir;
    assign exec_en   = (r_state == ST_EXEC);
    assign halted    = (r_state == ST_HALT);
    assign link_addr = w_pc_inc;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
// Directed testbench for fetch_unit: zero-wait and delayed fetches, branches,
// jumps, JAL link address, JR, PC wrap, HLT and reset during a fetch.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic [3:0]  opcode;
    logic [15:0] instr;
    logic [15:0] ctrl;
    logic        alu_zero;
    logic [15:0] jr_addr;
    logic        exec_en;
    logic [15:0] link_addr;
    logic        halted;
`ifdef FETCH_RESUME_EN
    logic        resume = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    fetch_unit #(
        .PC_W     (16),
        .INSTR_W  (16),
        .RESET_PC (0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .opcode     (opcode),
        .instr      (instr),
        .ctrl       (ctrl),
        .alu_zero   (alu_zero),
        .jr_addr    (jr_addr),
        .exec_en    (exec_en),
        .link_addr  (link_addr),
        .halted     (halted)
`ifdef FETCH_RESUME_EN
        ,
        .resume     (resume)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One zero-wait instruction: fetch at pc, execute, expect next fetch at nxt.
    task automatic run_instr(input string tag, input logic [15:0] rd, input logic [15:0] c,
                             input logic z, input logic [15:0] jr,
                             input logic [15:0] pc, input logic [15:0] nxt);
        logic [15:0] pc1;
        pc1 = pc + 16'd1;
        check({tag, "/addr"}, 32'(imem_addr), 32'(pc));
        check({tag, "/req"}, 32'(imem_req), 32'd1);
        check({tag, "/exec_lo"}, 32'(exec_en), 32'd0);
        imem_ack   = 1'b1;
        imem_rdata = rd;
        ctrl       = c;
        alu_zero   = z;
        jr_addr    = jr;
        step();
        imem_ack = 1'b0;
        check({tag, "/exec_hi"}, 32'(exec_en), 32'd1);
        check({tag, "/instr"}, 32'(instr), 32'(rd));
        check({tag, "/link"}, 32'(link_addr), 32'(pc1));
        step();
        check({tag, "/next"}, 32'(imem_addr), 32'(nxt));
    endtask

    initial begin
        rst        = 1'b1;
        imem_ack   = 1'b0;
        imem_rdata = 16'h0000;
        ctrl       = 16'h0000;
        alu_zero   = 1'b0;
        jr_addr    = 16'h0000;
        step();
        step();
        check("rst/req", 32'(imem_req), 32'd0);
        check("rst/addr", 32'(imem_addr), 32'h0);
        check("rst/opcode", 32'(opcode), 32'hE);
        check("rst/instr", 32'(instr), 32'hE000);
        check("rst/exec", 32'(exec_en), 32'd0);
        check("rst/halted", 32'(halted), 32'd0);
        rst = 1'b0;
        #1;

        // Zero-wait NOP stream.
        run_instr("nop0", 16'hE000, 16'h0001, 1'b0, 16'h0, 16'd0, 16'd1);
        run_instr("nop1", 16'hE000, 16'h0001, 1'b0, 16'h0, 16'd1, 16'd2);
        run_instr("nop2", 16'hE000, 16'h0001, 1'b0, 16'h0, 16'd2, 16'd3);
        run_instr("nop3", 16'hE000, 16'h0001, 1'b0, 16'h0, 16'd3, 16'd4);
        run_instr("nop4", 16'hE000, 16'h0001, 1'b0, 16'h0, 16'd4, 16'd5);

        // Ack delayed three cycles at PC=5.
        imem_rdata = 16'h1234;
        ctrl       = 16'h0001;
        for (int i = 0; i < 3; i++) begin
            check("wait/addr", 32'(imem_addr), 32'd5);
            check("wait/req", 32'(imem_req), 32'd1);
            check("wait/instr", 32'(instr), 32'hE000);
            check("wait/exec", 32'(exec_en), 32'd0);
            step();
        end
        check("wait/addr_ack", 32'(imem_addr), 32'd5);
        imem_ack = 1'b1;
        step();
        imem_ack = 1'b0;
        check("wait/exec_hi", 32'(exec_en), 32'd1);
        check("wait/instr_new", 32'(instr), 32'h1234);
        check("wait/opcode", 32'(opcode), 32'h1);
        step();
        check("wait/next", 32'(imem_addr), 32'd6);

        // Branches around PC=10 with offset -4.
        run_instr("j10",    16'h800A, 16'h0005, 1'b0, 16'h0, 16'd6,  16'd10);
        run_instr("beq_t",  16'h403C, 16'h000B, 1'b1, 16'h0, 16'd10, 16'd7);
        run_instr("brign",  16'hE000, 16'h0009, 1'b1, 16'h0, 16'd7,  16'd8);
        run_instr("j10b",   16'h800A, 16'h0005, 1'b0, 16'h0, 16'd8,  16'd10);
        run_instr("beq_nt", 16'h403C, 16'h000B, 1'b0, 16'h0, 16'd10, 16'd11);
        run_instr("j10c",   16'h800A, 16'h0005, 1'b0, 16'h0, 16'd11, 16'd10);
        run_instr("bne_t",  16'h503C, 16'h0013, 1'b0, 16'h0, 16'd10, 16'd7);
        run_instr("bne_nt", 16'h503C, 16'h0013, 1'b1, 16'h0, 16'd7,  16'd8);

        // Jumps, JAL link, JR and wrap.
        run_instr("j123",  16'h8123, 16'h0005, 1'b0, 16'h0,    16'd8,    16'h0123);
        run_instr("j20",   16'h8020, 16'h0005, 1'b0, 16'h0,    16'h0123, 16'h0020);
        run_instr("jal",   16'h9040, 16'h0005, 1'b0, 16'h0,    16'h0020, 16'h0040);
        run_instr("jr",    16'hA000, 16'h0007, 1'b0, 16'h4567, 16'h0040, 16'h4567);
        run_instr("jrff",  16'hA000, 16'h0007, 1'b0, 16'hFFFF, 16'h4567, 16'hFFFF);
        run_instr("wrap",  16'hE000, 16'h0001, 1'b0, 16'h0,    16'hFFFF, 16'h0000);
        run_instr("bwrap", 16'h403C, 16'h000B, 1'b1, 16'h0,    16'h0000, 16'hFFFD);
        run_instr("j8",    16'h8008, 16'h0005, 1'b0, 16'h0,    16'hFFFD, 16'h0008);

        // HLT at PC=8; acks while halted are ignored.
        imem_ack   = 1'b1;
        imem_rdata = 16'hF000;
        ctrl       = 16'h0000;
        step();
        imem_ack = 1'b0;
        check("hlt/exec", 32'(exec_en), 32'd1);
        step();
        imem_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("hlt/halted", 32'(halted), 32'd1);
            check("hlt/req", 32'(imem_req), 32'd0);
            check("hlt/exec_lo", 32'(exec_en), 32'd0);
            check("hlt/addr", 32'(imem_addr), 32'd8);
            step();
        end
        imem_ack = 1'b0;

        // Reset out of HALT.
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("hrst/halted", 32'(halted), 32'd0);
        check("hrst/addr", 32'(imem_addr), 32'd0);
        run_instr("nopr", 16'hE000, 16'h0001, 1'b0, 16'h0, 16'd0, 16'd1);

        // Reset coincident with an ack during FETCH: reset wins.
        imem_ack   = 1'b1;
        imem_rdata = 16'h1111;
        rst        = 1'b1;
        step();
        check("rack/addr", 32'(imem_addr), 32'd0);
        check("rack/opcode", 32'(opcode), 32'hE);
        check("rack/instr", 32'(instr), 32'hE000);
        check("rack/exec", 32'(exec_en), 32'd0);
        check("rack/req", 32'(imem_req), 32'd0);
        rst      = 1'b0;
        imem_ack = 1'b0;
        #1;
        check("rack/req_after", 32'(imem_req), 32'd1);
        step();
        check("rack/exec_after", 32'(exec_en), 32'd0);
        check("rack/opcode_after", 32'(opcode), 32'hE);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
